branch_resolver: RTL

- Resolves conditional branches (beq opcode 4, bne opcode 5) in Execute and closes the loop with the gshare direction predictor.
- Tracks each fetched branch's prediction, PHT index and GHR checkpoint through the F/D and D/E stages.
- Owns the speculative global history register (GHR) fed to the predictor at Fetch.
- Produces the PHT update (index, outcome, enable), the mispredict flush and the redirect PC, and keeps branch and mispredict statistics.

---
 rtl/branch_resolver.sv | 131 +++++++++++++
 1 files changed

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - gshare branch resolution, speculative GHR and mispredict recovery
module branch_resolver #(
    parameter int PC_W  = 32,
    parameter int GHR_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  pc_F,
    input  logic [5:0]       opcode_F,
    input  logic             prediction_F,
    input  logic             stall,
    output logic [GHR_W-1:0] ghr_F,
    input  logic             branch_E,
    input  logic             bne_E,
    input  logic             eq_E,
    input  logic [PC_W-1:0]  target_E,
    output logic             update_en_E,
    output logic [GHR_W-1:0] pc_xor_gr_E,
    output logic             taken_E,
    output logic             mispredict_E,
    output logic [PC_W-1:0]  redirect_pc_E,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [5:0] OP_BEQ = 6'd4;
    localparam logic [5:0] OP_BNE = 6'd5;

    logic [GHR_W-1:0] ghr_spec;

    logic             fd_valid;
    logic             fd_is_br;
    logic             fd_pred;
    logic [PC_W-1:0]  fd_pc;
    logic [GHR_W-1:0] fd_ghr_ckpt;

    logic             de_valid;
    logic             de_is_br;
    logic             de_pred;
    logic [PC_W-1:0]  de_pc;
    logic [GHR_W-1:0] de_ghr_ckpt;

    logic is_br_F;
    logic br_E;

    assign is_br_F = (opcode_F == OP_BEQ) || (opcode_F == OP_BNE);
    assign ghr_F   = ghr_spec;

    // The decoder's E-stage view is authoritative; the carried is_br bit only cross-checks it.
    always_comb begin
        br_E          = de_valid && (branch_E || bne_E);
        taken_E       = br_E && (branch_E ? eq_E : ~eq_E);
        update_en_E   = br_E;
        pc_xor_gr_E   = de_pc[GHR_W-1:0] ^ de_ghr_ckpt;
        mispredict_E  = br_E && (de_pred != taken_E);
        redirect_pc_E = '0;
        if (mispredict_E) begin
            redirect_pc_E = taken_E ? target_E : de_pc + PC_W'(1);
        end
    end

    // A mispredict rebuilds history from the resolved branch's checkpoint, discarding any younger shifts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr_spec <= '0;
        end else if (mispredict_E) begin
            ghr_spec <= {de_ghr_ckpt[GHR_W-2:0], taken_E};
        end else if (is_br_F && !stall) begin
            ghr_spec <= {ghr_spec[GHR_W-2:0], prediction_F};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fd_valid <= 1'b0;
        end else if (mispredict_E) begin
            fd_valid <= 1'b0;
        end else if (!stall) begin
            fd_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            fd_is_br    <= is_br_F;
            fd_pred     <= prediction_F;
            fd_pc       <= pc_F;
            fd_ghr_ckpt <= ghr_spec;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            de_valid <= 1'b0;
        end else if (mispredict_E || stall) begin
            de_valid <= 1'b0;
        end else begin
            de_valid <= fd_valid;
        end
    end

    always_ff @(posedge clk) begin
        de_is_br    <= fd_is_br;
        de_pred     <= fd_pred;
        de_pc       <= fd_pc;
        de_ghr_ckpt <= fd_ghr_ckpt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (update_en_E && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + 1'b1;
            end
            if (mispredict_E && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && de_valid && (branch_E || bne_E)) begin
            assert (de_is_br)
                else $error("decoder flags a branch in E that was not a branch opcode at fetch");
        end
    end

endmodule
